// File: rtl/shift_lane_serializer_if.sv
// Handshake bundle for shift_lane_serializer.
//   par_data_i/par_valid_i/par_ready_o : parallel word in (valid/ready)
//   ser_data_o/ser_valid_o/ser_ready_i : serial beats out (valid/ready)
//   ser_last_o                         : final beat of the current word
//   busy_o                             : a word is being serialized
// Signal suffixes are from the serializer's point of view.
// slave is the serializer's view; master is the surrounding logic's view.
interface shift_lane_serializer_if #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned LANES = 1
) ();
  logic [WIDTH-1:0] par_data_i;
  logic             par_valid_i;
  logic             par_ready_o;
  logic [LANES-1:0] ser_data_o;
  logic             ser_valid_o;
  logic             ser_ready_i;
  logic             ser_last_o;
  logic             busy_o;

  modport slave (
    input  par_data_i, par_valid_i, ser_ready_i,
    output par_ready_o, ser_data_o, ser_valid_o, ser_last_o, busy_o
  );

  modport master (
    output par_data_i, par_valid_i, ser_ready_i,
    input  par_ready_o, ser_data_o, ser_valid_o, ser_last_o, busy_o
  );
endinterface

// File: rtl/shift_lane_serializer.sv
// Parallel-to-serial converter: accepts a WIDTH-bit word and emits it as
// WIDTH/LANES beats of LANES bits, MSB lane first or LSB lane first.
//   clk   : clock, rising edge
//   reset : asynchronous, active-high
//   bus   : shift_lane_serializer_if.slave (parallel in, serial out, busy)
// A new word may be accepted in the same cycle the last beat is consumed,
// so back-to-back words stream without a bubble.
module shift_lane_serializer #(
  parameter int unsigned WIDTH     = 32,
  parameter int unsigned LANES     = 1,
  parameter bit          MSB_FIRST = 1'b1
) (
  input  logic                   clk,
  input  logic                   reset,
  shift_lane_serializer_if.slave bus
);

  localparam int unsigned BEATS = WIDTH / LANES;
  localparam int unsigned CW    = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam logic [CW-1:0] LAST_CNT = CW'(BEATS - 1);

  if ((LANES < 1) || (LANES > WIDTH) || ((WIDTH % LANES) != 0)) begin : g_bad_params
    $error("shift_lane_serializer: need WIDTH >= LANES >= 1 and WIDTH divisible by LANES");
  end

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] sreg_q, sreg_d;
  logic [CW-1:0]    cnt_q, cnt_d;

  logic             last;
  logic             par_ready;
  logic [WIDTH-1:0] shifted;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      sreg_q  <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      sreg_q  <= sreg_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    sreg_d    = sreg_q;
    cnt_d     = cnt_q;
    last      = (state_q == SHIFT) && (cnt_q == LAST_CNT);
    // Ready while shifting only when the last beat leaves this cycle,
    // letting the next word load on the same edge.
    par_ready = (state_q == IDLE) || (last && bus.ser_ready_i);
    shifted   = MSB_FIRST ? (sreg_q << LANES) : (sreg_q >> LANES);

    unique case (state_q)
      IDLE: begin
        if (bus.par_valid_i) begin
          sreg_d  = bus.par_data_i;
          cnt_d   = '0;
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        if (bus.ser_ready_i) begin
          if (last) begin
            if (bus.par_valid_i) begin
              sreg_d = bus.par_data_i;
              cnt_d  = '0;
            end else begin
              sreg_d  = '0;
              cnt_d   = '0;
              state_d = IDLE;
            end
          end else begin
            sreg_d = shifted;
            cnt_d  = cnt_q + CW'(1);
          end
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_comb begin
    bus.par_ready_o = par_ready;
    bus.ser_valid_o = (state_q == SHIFT);
    bus.busy_o      = (state_q == SHIFT);
    bus.ser_last_o  = last;
    bus.ser_data_o  = '0;
    if (state_q == SHIFT) begin
      bus.ser_data_o = MSB_FIRST ? sreg_q[WIDTH-1 -: LANES] : sreg_q[LANES-1:0];
    end
  end

endmodule

// File: tb/tb_shift_lane_serializer.sv
// Self-checking bench for shift_lane_serializer with three instances:
//   dut0: WIDTH=8 LANES=2 MSB first, dut1: WIDTH=8 LANES=2 LSB first,
//   dut2: WIDTH=4 LANES=4 (one beat per word).
// A word-level model (current word, beat index) predicts every output on
// every cycle; directed sequences pin the model with literal beat lists.
module tb_shift_lane_serializer;

  localparam int unsigned CFG_W [3] = '{8, 8, 4};
  localparam int unsigned CFG_L [3] = '{2, 2, 4};
  localparam int unsigned CFG_M [3] = '{1, 0, 1};

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic        pv [3];
  logic [31:0] pd [3];
  logic        sr [3];

  logic [31:0] o_dat  [3];
  logic        o_rdy  [3];
  logic        o_val  [3];
  logic        o_last [3];
  logic        o_busy [3];

  shift_lane_serializer_if #(.WIDTH(8), .LANES(2)) b0 ();
  shift_lane_serializer_if #(.WIDTH(8), .LANES(2)) b1 ();
  shift_lane_serializer_if #(.WIDTH(4), .LANES(4)) b2 ();

  shift_lane_serializer #(.WIDTH(8), .LANES(2), .MSB_FIRST(1'b1)) u0 (.clk(clk), .reset(rst), .bus(b0.slave));
  shift_lane_serializer #(.WIDTH(8), .LANES(2), .MSB_FIRST(1'b0)) u1 (.clk(clk), .reset(rst), .bus(b1.slave));
  shift_lane_serializer #(.WIDTH(4), .LANES(4), .MSB_FIRST(1'b1)) u2 (.clk(clk), .reset(rst), .bus(b2.slave));

  assign b0.par_data_i  = pd[0][7:0];
  assign b0.par_valid_i = pv[0];
  assign b0.ser_ready_i = sr[0];
  assign b1.par_data_i  = pd[1][7:0];
  assign b1.par_valid_i = pv[1];
  assign b1.ser_ready_i = sr[1];
  assign b2.par_data_i  = pd[2][3:0];
  assign b2.par_valid_i = pv[2];
  assign b2.ser_ready_i = sr[2];

  assign o_dat[0]  = 32'(b0.ser_data_o);
  assign o_rdy[0]  = b0.par_ready_o;
  assign o_val[0]  = b0.ser_valid_o;
  assign o_last[0] = b0.ser_last_o;
  assign o_busy[0] = b0.busy_o;
  assign o_dat[1]  = 32'(b1.ser_data_o);
  assign o_rdy[1]  = b1.par_ready_o;
  assign o_val[1]  = b1.ser_valid_o;
  assign o_last[1] = b1.ser_last_o;
  assign o_busy[1] = b1.busy_o;
  assign o_dat[2]  = 32'(b2.ser_data_o);
  assign o_rdy[2]  = b2.par_ready_o;
  assign o_val[2]  = b2.ser_valid_o;
  assign o_last[2] = b2.ser_last_o;
  assign o_busy[2] = b2.busy_o;

  // Model: whether a word is in flight, the word itself, which beat is shown.
  logic        m_act [3];
  logic [31:0] m_wd  [3];
  int unsigned m_bt  [3];

  function automatic int unsigned beats(input int i);
    return CFG_W[i] / CFG_L[i];
  endfunction

  function automatic logic m_last(input int i);
    return m_act[i] && (m_bt[i] == beats(i) - 1);
  endfunction

  function automatic logic m_rdy(input int i);
    return !m_act[i] || (m_last(i) && sr[i]);
  endfunction

  function automatic logic [31:0] m_data(input int i);
    int unsigned sh;
    if (!m_act[i]) return 32'd0;
    sh = (CFG_M[i] != 0) ? CFG_W[i] - CFG_L[i] * (m_bt[i] + 1) : CFG_L[i] * m_bt[i];
    return (m_wd[i] >> sh) & ((32'd1 << CFG_L[i]) - 32'd1);
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 3; i++) begin
        m_act[i] <= 1'b0;
        m_bt[i]  <= 0;
        m_wd[i]  <= 32'd0;
      end
    end else begin
      for (int i = 0; i < 3; i++) begin
        m_act[i] <= (m_act[i] && !(sr[i] && m_last(i))) || (pv[i] && m_rdy(i));
        m_bt[i]  <= (pv[i] && m_rdy(i)) ? 0 :
                    (m_act[i] && sr[i]) ? (m_last(i) ? 0 : m_bt[i] + 1) : m_bt[i];
        m_wd[i]  <= (pv[i] && m_rdy(i)) ? (pd[i] & ((32'd1 << CFG_W[i]) - 32'd1)) : m_wd[i];
      end
    end
  end

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  // Consumed beats, encoded as data + 16*last, with the cycle they left.
  int unsigned cq0[$];
  int unsigned cq1[$];
  int unsigned cq2[$];
  int          cc0[$];
  int          cc2[$];

  task automatic chk(input string nm, input logic [31:0] a, input logic [31:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h t=%0t", nm, a, e, $time);
    end
  endtask

  task automatic cmp_all();
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("par_ready[%0d]", i), 32'(o_rdy[i]),  32'(m_rdy(i)));
      chk($sformatf("ser_valid[%0d]", i), 32'(o_val[i]),  32'(m_act[i]));
      chk($sformatf("busy[%0d]", i),      32'(o_busy[i]), 32'(m_act[i]));
      chk($sformatf("ser_last[%0d]", i),  32'(o_last[i]), 32'(m_last(i)));
      chk($sformatf("ser_data[%0d]", i),  o_dat[i],       m_data(i));
      if (o_val[i] === 1'b1 && sr[i]) begin
        case (i)
          0: begin cq0.push_back(o_dat[0] + (o_last[0] ? 16 : 0)); cc0.push_back(cyc); end
          1: cq1.push_back(o_dat[1] + (o_last[1] ? 16 : 0));
          default: begin cq2.push_back(o_dat[2] + (o_last[2] ? 16 : 0)); cc2.push_back(cyc); end
        endcase
      end
    end
  endtask

  task automatic tick();
    @(negedge clk);
    cmp_all();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic chk_seq(input string nm, input int unsigned got[$], input int unsigned exp[$]);
    chk({nm, "_len"}, 32'(got.size()), 32'(exp.size()));
    for (int k = 0; k < exp.size(); k++)
      chk($sformatf("%s_beat%0d", nm, k), (k < got.size()) ? got[k] : 32'hFFFF, exp[k]);
  endtask

  task automatic clear_caps();
    cq0.delete(); cq1.delete(); cq2.delete(); cc0.delete(); cc2.delete();
  endtask

  initial begin
    int unsigned e[$];
    for (int i = 0; i < 3; i++) begin
      pv[i] = 1'b0; pd[i] = 32'd0; sr[i] = 1'b1;
    end
    rst = 1'b1;
    @(posedge clk);
    #1;
    // Reset values with reset held.
    chk("rst_par_ready", 32'(o_rdy[0]),  32'd1);
    chk("rst_ser_valid", 32'(o_val[0]),  32'd0);
    chk("rst_ser_data",  o_dat[0],       32'd0);
    chk("rst_ser_last",  32'(o_last[0]), 32'd0);
    chk("rst_busy",      32'(o_busy[0]), 32'd0);
    tick();
    rst = 1'b0;
    tick();

    // 0xB4 on both 8/2 instances.
    clear_caps();
    pd[0] = 32'hB4; pd[1] = 32'hB4; pv[0] = 1'b1; pv[1] = 1'b1;
    tick();
    pv[0] = 1'b0; pv[1] = 1'b0;
    repeat (6) tick();
    e = '{2, 3, 1, 16};
    chk_seq("msb_b4", cq0, e);
    e = '{0, 1, 3, 18};
    chk_seq("lsb_b4", cq1, e);

    // 0xB4 then 0x5A with valid held: no bubble.
    clear_caps();
    pd[0] = 32'hB4; pv[0] = 1'b1;
    tick();
    pd[0] = 32'h5A;
    repeat (4) tick();
    pv[0] = 1'b0;
    repeat (6) tick();
    e = '{2, 3, 1, 16, 1, 1, 2, 18};
    chk_seq("b2b", cq0, e);
    chk("b2b_span", 32'((cc0.size() == 8) ? cc0[7] - cc0[0] : -1), 32'd7);

    // Stall for 3 cycles while beat value 3 is shown.
    clear_caps();
    pd[0] = 32'hB4; pv[0] = 1'b1;
    tick();
    pv[0] = 1'b0;
    tick();
    sr[0] = 1'b0;
    repeat (3) begin
      tick();
      chk("stall_hold", o_dat[0], 32'd3);
    end
    sr[0] = 1'b1;
    repeat (5) tick();
    e = '{2, 3, 1, 16};
    chk_seq("stall", cq0, e);

    // Asynchronous reset after the second beat.
    pd[0] = 32'hB4; pv[0] = 1'b1;
    tick();
    pv[0] = 1'b0;
    tick();
    tick();
    #2 rst = 1'b1;
    #1;
    chk("arst_par_ready", 32'(o_rdy[0]),  32'd1);
    chk("arst_ser_valid", 32'(o_val[0]),  32'd0);
    chk("arst_ser_data",  o_dat[0],       32'd0);
    chk("arst_ser_last",  32'(o_last[0]), 32'd0);
    chk("arst_busy",      32'(o_busy[0]), 32'd0);
    tick();
    rst = 1'b0;
    tick();
    clear_caps();
    pd[0] = 32'h0F; pv[0] = 1'b1;
    tick();
    pv[0] = 1'b0;
    repeat (6) tick();
    e = '{0, 0, 3, 19};
    chk_seq("after_rst", cq0, e);

    // Single-beat words stream one per cycle.
    clear_caps();
    pd[2] = 32'hA; pv[2] = 1'b1;
    tick();
    pd[2] = 32'h3;
    tick();
    pv[2] = 1'b0;
    repeat (3) tick();
    e = '{26, 19};
    chk_seq("one_beat", cq2, e);
    chk("one_beat_span", 32'((cc2.size() == 2) ? cc2[1] - cc2[0] : -1), 32'd1);

    // Random traffic, stalls and occasional resets on all instances.
    repeat (3000) begin
      for (int i = 0; i < 3; i++) begin
        pv[i] = ($urandom_range(0, 3) != 0);
        pd[i] = $urandom;
        sr[i] = ($urandom_range(0, 3) != 0);
      end
      rst = ($urandom_range(0, 399) == 0);
      tick();
    end
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      pv[i] = 1'b0; sr[i] = 1'b1;
    end
    repeat (10) tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/shift_lane_serializer.md
SHIFT_LANE_SERIALIZER -- requirements
Module: shift_lane_serializer

Interface
REQ-001 Parameter WIDTH, default 32, parallel word width in bits.
REQ-002 Parameter LANES, default 1, serial bits output per beat.
REQ-003 Parameter MSB_FIRST, default 1; 1 = most significant lane first, 0 = least significant lane first.
REQ-004 clk  input  1  clock; all state updates on the rising edge.
REQ-005 reset  input  1  asynchronous, active-high reset.
REQ-006 par_data_i  input  WIDTH  parallel word to serialize.
REQ-007 par_valid_i  input  1  par_data_i is valid.
REQ-008 par_ready_o  output  1  block accepts a word this cycle.
REQ-009 ser_data_o  output  LANES  current serial beat.
REQ-010 ser_valid_o  output  1  ser_data_o is valid.
REQ-011 ser_ready_i  input  1  downstream consumes the beat this cycle.
REQ-012 ser_last_o  output  1  current beat is the final beat of the word.
REQ-013 busy_o  output  1  a word is being serialized.

Function
REQ-014 BEATS = WIDTH/LANES; elaboration SHALL fail unless WIDTH >= LANES >= 1 and WIDTH mod LANES = 0.
REQ-015 Beat counter width = max(1, clog2(BEATS)); counter range 0..BEATS-1 and never wraps past BEATS-1.
REQ-016 FSM has two states, IDLE and SHIFT.
REQ-017 Transfers: parallel transfer = par_valid_i & par_ready_o; serial transfer = ser_valid_o & ser_ready_i.
REQ-018 par_ready_o = (IDLE) | (SHIFT & ser_last_o & ser_ready_i); this is a combinational path from ser_ready_i.
REQ-019 IDLE with parallel transfer: load par_data_i, clear counter, go to SHIFT.
REQ-020 IDLE without a transfer: hold state.
REQ-021 Load latency: first beat valid in the cycle after the accepting edge.
REQ-022 SHIFT: ser_valid_o = 1 and busy_o = 1.
REQ-023 IDLE: ser_valid_o = 0, busy_o = 0, ser_data_o = 0, ser_last_o = 0.
REQ-024 MSB_FIRST=1: ser_data_o = shift register bits [WIDTH-1 -: LANES]; on a serial transfer, shift left by LANES and fill with zeros.
REQ-025 MSB_FIRST=0: ser_data_o = shift register bits [LANES-1:0]; on a serial transfer, shift right by LANES and fill with zeros.
REQ-026 ser_last_o = SHIFT & (counter = BEATS-1).
REQ-027 Serial transfer, not last beat: shift the register and increment the counter.
REQ-028 SHIFT with ser_ready_i = 0 (stall): hold register, counter, ser_data_o and ser_last_o unchanged for any stall length.
REQ-029 Serial transfer on the last beat with par_valid_i = 1: load the new word, clear the counter, stay in SHIFT; no bubble cycle.
REQ-030 Serial transfer on the last beat with par_valid_i = 0: go to IDLE.
REQ-031 BEATS = 1: every beat is last; back-to-back words SHALL stream one per cycle.
REQ-032 par_valid_i is ignored while par_ready_o = 0; the word is not captured and is not lost-flagged.
REQ-033 Serial throughput with no stalls: exactly BEATS cycles per word.

Reset
REQ-034 While reset is high: state = IDLE, shift register = 0, counter = 0.
REQ-035 While reset is high: par_ready_o = 1, ser_valid_o = 0, ser_data_o = 0, ser_last_o = 0, busy_o = 0.
REQ-036 Reset asserted mid-word discards the remaining beats; after release, the block starts in IDLE.

Verification
REQ-037 WIDTH=8, LANES=2, MSB_FIRST=1, load 0xB4, ser_ready_i=1 -> beats 2,3,1,0 on 4 consecutive cycles; ser_last_o only on beat 0; then IDLE.
REQ-038 Same word with MSB_FIRST=0 -> beats 0,1,3,2; ser_last_o on the 4th beat.
REQ-039 Same config, 0xB4 then 0x5A, par_valid_i held high -> beats 2,3,1,0,1,1,2,2 with no gap; par_ready_o high only on the last-beat cycle.
REQ-040 ser_ready_i low for 3 cycles after beat 1 -> ser_data_o=3 held for 3 cycles, counter frozen; sequence completes unchanged.
REQ-041 Reset pulsed after the second beat of 0xB4 -> all outputs reach reset values asynchronously; next load 0x0F yields 0,0,3,3.
REQ-042 WIDTH=4, LANES=4 -> words 0xA, 0x3 on consecutive cycles give ser_data_o A then 3, with ser_last_o=1 on both.
